if_fetch_unit: RTL and testbench

//  Instruction-fetch stage for the RV32I core: owns the PC, issues word reads to instruction memory,
//  and presents each fetched instruction to the control unit / decode stage.

---
 rtl/if_fetch_unit_if.sv | 26 ++
 rtl/if_fetch_unit.sv | 119 +++++++++++
 tb/tb_if_fetch_unit.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_unit_if.sv
// Fetch-stage bus: instruction-memory request/response plus the decode-side handshake and redirect.
// master = fetch unit, slave = memory/decode side.
interface if_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        pc_src;
  logic [31:0] pc_target;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc4;
  logic        instr_valid;
  logic        instr_ready;
  logic        misalign_err;

  modport master (
    output imem_req, imem_addr, instr, instr_pc, instr_pc4, instr_valid, misalign_err,
    input  imem_ack, imem_rdata, pc_src, pc_target, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr, instr_pc, instr_pc4, instr_valid, misalign_err,
    output imem_ack, imem_rdata, pc_src, pc_target, instr_ready
  );
endinterface

// File: rtl/if_fetch_unit.sv
// RV32I instruction-fetch stage: owns the PC, issues single outstanding word reads and
// presents each fetched instruction to decode with a valid/ready handshake.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input logic       clk,
  input logic       rst,
  if_fetch_unit_if.master bus
);

  typedef enum logic [1:0] {StIdle, StFetch, StHold, StDrop} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic [31:0] instr_pc4_q, instr_pc4_d;
  logic        misalign_q, misalign_d;

  logic [31:0] target;
  logic [31:0] req_addr_inc;

  assign target       = {bus.pc_target[31:2], 2'b00};
  assign req_addr_inc = req_addr_q + 32'd4;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_addr_d  = req_addr_q;
    instr_d     = instr_q;
    instr_pc_d  = instr_pc_q;
    instr_pc4_d = instr_pc4_q;
    misalign_d  = misalign_q;

    // Redirects are ignored while idle, so misalignment is only flagged in the active states.
    if (state_q != StIdle && bus.pc_src && bus.pc_target[1:0] != 2'b00) begin
      misalign_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        state_d    = StFetch;
        req_addr_d = pc_q;
      end
      StFetch: begin
        if (bus.pc_src) begin
          pc_d = target;
          if (bus.imem_ack) begin
            req_addr_d = target;
          end else begin
            state_d = StDrop;
          end
        end else if (bus.imem_ack) begin
          instr_d     = bus.imem_rdata;
          instr_pc_d  = req_addr_q;
          instr_pc4_d = req_addr_inc;
          pc_d        = req_addr_inc;
          state_d     = StHold;
        end
      end
      StHold: begin
        if (bus.pc_src) begin
          pc_d       = target;
          req_addr_d = target;
          instr_d    = NOP_INSTR;
          state_d    = StFetch;
        end else if (bus.instr_ready) begin
          req_addr_d = pc_q;
          instr_d    = NOP_INSTR;
          state_d    = StFetch;
        end
      end
      StDrop: begin
        // The stale request must complete; its data is discarded and the newest target wins.
        if (bus.pc_src) begin
          pc_d = target;
        end
        if (bus.imem_ack) begin
          req_addr_d = bus.pc_src ? target : pc_q;
          state_d    = StFetch;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      pc_q        <= RESET_PC;
      req_addr_q  <= RESET_PC;
      instr_q     <= NOP_INSTR;
      instr_pc_q  <= RESET_PC;
      instr_pc4_q <= RESET_PC + 32'd4;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_addr_q  <= req_addr_d;
      instr_q     <= instr_d;
      instr_pc_q  <= instr_pc_d;
      instr_pc4_q <= instr_pc4_d;
      misalign_q  <= misalign_d;
    end
  end

  assign bus.imem_req     = (state_q == StFetch) || (state_q == StDrop);
  assign bus.imem_addr    = req_addr_q;
  assign bus.instr_valid  = (state_q == StHold);
  assign bus.instr        = instr_q;
  assign bus.instr_pc     = instr_pc_q;
  assign bus.instr_pc4    = instr_pc4_q;
  assign bus.misalign_err = misalign_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: table-driven sequential fetches plus hand-written
// redirect, flush, misalignment, wrap-around and reset sequences.
module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk;
  logic rst;
  if_fetch_unit_if bus ();

  if_fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (NOP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] rdata;
    int          delay;
    int          stall;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[4];
  int   checks = 0;
  int   errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  task automatic check1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", nm, act, exp);
    end
  endtask

  task automatic wait_req(input string nm, input logic [31:0] a);
    int n = 0;
    while (!bus.imem_req && n < 20) begin
      tick();
      n++;
    end
    check1({nm, "_req"}, bus.imem_req, 1'b1);
    check32({nm, "_addr"}, bus.imem_addr, a);
  endtask

  // Pop the oldest expected instruction and compare it with what decode currently sees.
  task automatic sb_check(input string nm);
    exp_t e;
    check1({nm, "_valid"}, bus.instr_valid, 1'b1);
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s_sb: got instr %08h expected empty scoreboard", nm, bus.instr);
    end else begin
      e = sb.pop_front();
      check32({nm, "_instr"}, bus.instr, e.instr);
      check32({nm, "_pc"}, bus.instr_pc, e.pc);
      check32({nm, "_pc4"}, bus.instr_pc4, e.pc4);
    end
  endtask

  task automatic do_fetch(input string nm, input logic [31:0] a, input logic [31:0] d,
                          input int delay, input int stall);
    exp_t e;
    wait_req(nm, a);
    for (int i = 0; i < delay; i++) begin
      tick();
      check32({nm, "_wait_addr"}, bus.imem_addr, a);
    end
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = d;
    e.instr = d;
    e.pc    = a;
    e.pc4   = a + 32'd4;
    sb.push_back(e);
    tick();
    bus.imem_ack = 1'b0;
    sb_check(nm);
    for (int i = 0; i < stall; i++) begin
      tick();
      check1({nm, "_stall_valid"}, bus.instr_valid, 1'b1);
      check1({nm, "_stall_req"}, bus.imem_req, 1'b0);
      check32({nm, "_stall_instr"}, bus.instr, d);
      check32({nm, "_stall_pc"}, bus.instr_pc, a);
    end
    bus.instr_ready = 1'b1;
    tick();
    bus.instr_ready = 1'b0;
  endtask

  task automatic redirect(input logic [31:0] t, input logic ack);
    bus.pc_src    = 1'b1;
    bus.pc_target = t;
    bus.imem_ack  = ack;
    tick();
    bus.pc_src   = 1'b0;
    bus.imem_ack = 1'b0;
  endtask

  initial begin
    vecs[0] = '{addr: 32'h0, rdata: 32'h0050_0093, delay: 0, stall: 0};
    vecs[1] = '{addr: 32'h4, rdata: 32'h00A0_0113, delay: 0, stall: 0};
    vecs[2] = '{addr: 32'h8, rdata: 32'h0011_8193, delay: 2, stall: 5};
    vecs[3] = '{addr: 32'hC, rdata: 32'h0022_0213, delay: 1, stall: 1};

    rst            = 1'b1;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 32'h0;
    bus.pc_src     = 1'b0;
    bus.pc_target  = 32'h0;
    bus.instr_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check1("rst_req", bus.imem_req, 1'b0);
    check1("rst_valid", bus.instr_valid, 1'b0);
    check32("rst_instr", bus.instr, NOP);
    check32("rst_addr", bus.imem_addr, 32'h0);
    check32("rst_pc4", bus.instr_pc4, 32'h4);
    check1("rst_misalign", bus.misalign_err, 1'b0);
    rst = 1'b0;
    check1("idle_req", bus.imem_req, 1'b0);
    tick();
    check1("first_req", bus.imem_req, 1'b1);
    check32("first_addr", bus.imem_addr, 32'h0);

    // Sequential fetches, with memory wait states and decode stalls
    for (int i = 0; i < 4; i++) begin
      do_fetch($sformatf("vec%0d", i), vecs[i].addr, vecs[i].rdata, vecs[i].delay,
               vecs[i].stall);
    end

    // Redirect while a request is outstanding: stale data must be dropped
    wait_req("drop", 32'h10);
    redirect(32'h100, 1'b0);
    check1("drop_req", bus.imem_req, 1'b1);
    check32("drop_old_addr", bus.imem_addr, 32'h10);
    repeat (2) tick();
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'hDEAD_BEEF;
    tick();
    bus.imem_ack = 1'b0;
    check1("drop_valid", bus.instr_valid, 1'b0);
    check32("drop_instr", bus.instr, NOP);
    check32("drop_new_addr", bus.imem_addr, 32'h100);
    do_fetch("tgt100", 32'h100, 32'h0010_0193, 0, 0);

    // Redirect in the same cycle as ack
    wait_req("rdack", 32'h104);
    bus.imem_rdata = 32'h0000_0BAD;
    redirect(32'h200, 1'b1);
    check1("rdack_valid", bus.instr_valid, 1'b0);
    check1("rdack_req", bus.imem_req, 1'b1);
    check32("rdack_addr", bus.imem_addr, 32'h200);

    // Redirect while holding an unaccepted instruction flushes it
    wait_req("hflush", 32'h200);
    begin
      exp_t e;
      e.instr = 32'h0000_0213;
      e.pc    = 32'h200;
      e.pc4   = 32'h204;
      sb.push_back(e);
    end
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'h0000_0213;
    tick();
    bus.imem_ack = 1'b0;
    sb_check("hflush");
    redirect(32'h300, 1'b0);
    check1("hflush_valid", bus.instr_valid, 1'b0);
    check32("hflush_instr", bus.instr, NOP);
    check32("hflush_addr", bus.imem_addr, 32'h300);

    // Two redirects while draining: the later target wins
    redirect(32'h400, 1'b0);
    redirect(32'h500, 1'b0);
    check1("latest_req", bus.imem_req, 1'b1);
    check32("latest_old_addr", bus.imem_addr, 32'h300);
    bus.imem_ack = 1'b1;
    tick();
    bus.imem_ack = 1'b0;
    check32("latest_addr", bus.imem_addr, 32'h500);
    check1("latest_misalign", bus.misalign_err, 1'b0);

    // Misaligned target, then PC wrap-around
    redirect(32'h102, 1'b1);
    check32("mis_addr", bus.imem_addr, 32'h100);
    check1("mis_err", bus.misalign_err, 1'b1);
    redirect(32'hFFFF_FFFC, 1'b1);
    do_fetch("wrap", 32'hFFFF_FFFC, 32'h0000_0293, 1, 1);
    wait_req("wrap_next", 32'h0);
    check1("mis_sticky", bus.misalign_err, 1'b1);

    // Asynchronous reset mid-request, with a late ack that must be ignored
    #2;
    rst          = 1'b1;
    bus.imem_ack = 1'b1;
    bus.imem_rdata = 32'hBAAD_F00D;
    #1;
    check1("mrst_req", bus.imem_req, 1'b0);
    check1("mrst_valid", bus.instr_valid, 1'b0);
    check32("mrst_addr", bus.imem_addr, 32'h0);
    check1("mrst_misalign", bus.misalign_err, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    bus.imem_ack = 1'b0;
    check1("mrst_fetch_req", bus.imem_req, 1'b1);
    check1("mrst_fetch_valid", bus.instr_valid, 1'b0);
    check32("mrst_instr", bus.instr, NOP);
    do_fetch("post_rst", 32'h0, 32'h0030_0313, 0, 0);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_empty: got %0d entries expected 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
